// File: rtl/rtc_pkg.sv
// rtl/rtc_pkg.sv - shared states, phase stage codes and bus defaults for the RTC timer write path
package rtc_pkg;

    // Transfer sequencer states: each transfer is an address phase, a data
    // phase and a one-cycle bus release.
    typedef enum logic [3:0] {
        IDLE,
        A_SETUP,
        A_STROBE,
        A_HOLD,
        D_SETUP,
        D_STROBE,
        D_HOLD,
        GAP,
        DONE
    } wr_state_e;

    // Stage codes handed to the dwell sequencer when a stage is entered.
    localparam logic [1:0] PH_SETUP  = 2'd0;
    localparam logic [1:0] PH_STROBE = 2'd1;
    localparam logic [1:0] PH_HOLD   = 2'd2;

    localparam logic [7:0] DEF_ADDR_BASE = 8'h41;
    localparam logic [7:0] DEF_ADDR_CMD  = 8'hF2;
    localparam logic [7:0] DEF_CMD_START = 8'h08;

    // Pad levels while the bus is released.
    localparam logic BUS_IDLE_CS_N = 1'b1;
    localparam logic BUS_IDLE_OE   = 1'b0;

    // Transfers 0..2 are seconds/minutes/hours, 3 is the start command.
    localparam logic [1:0] LAST_INDEX = 2'd3;

endpackage

// File: rtl/rtc_bus_phase.sv
// rtl/rtc_bus_phase.sv - setup/strobe/hold dwell sequencer shared by address and data phases
//
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   go         : a new stage starts on the next cycle (load the dwell counter)
//   stage      : which stage go starts (PH_SETUP / PH_STROBE / PH_HOLD)
//   strobe_n   : registered write strobe, low for the whole strobe stage
//   last       : current cycle is the final cycle of the running stage
module rtc_bus_phase
    import rtc_pkg::*;
#(
    parameter int T_SETUP  = 2,
    parameter int T_STROBE = 4,
    parameter int T_HOLD   = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       go,
    input  logic [1:0] stage,
    output logic       strobe_n,
    output logic       last
);

    localparam int MAX_AB    = (T_SETUP > T_STROBE) ? T_SETUP : T_STROBE;
    localparam int MAX_DWELL = (MAX_AB > T_HOLD) ? MAX_AB : T_HOLD;
    localparam int CW        = ($clog2(MAX_DWELL) < 3) ? 3 : $clog2(MAX_DWELL);

    logic [CW-1:0] cnt;
    logic [CW-1:0] load_val;

    // The counter holds "cycles remaining after this one", so a 1-cycle
    // stage loads zero and is last immediately.
    always_comb begin
        case (stage)
            PH_STROBE: load_val = CW'(T_STROBE - 1);
            PH_HOLD:   load_val = CW'(T_HOLD - 1);
            default:   load_val = CW'(T_SETUP - 1);
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt      <= '0;
            strobe_n <= 1'b1;
        end else if (go) begin
            cnt      <= load_val;
            strobe_n <= (stage != PH_STROBE);
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign last = (cnt == '0);

endmodule

// File: rtl/rtc_timer_writer.sv
// rtl/rtc_timer_writer.sv - writes BCD h/m/s and the start command over the RTC multiplexed bus
//
// Ports:
//   clk, reset            : clock and synchronous active-high reset
//   start                 : write request, only honoured in IDLE
//   in_hora/in_min/in_seg : BCD time value, latched when the request is accepted
//   busy, done            : transaction in progress / one-cycle completion pulse
//   rtc_cs_n, rtc_wr_n    : active-low chip select and write strobe
//   rtc_rd_n              : read strobe, held inactive
//   rtc_ad                : 0 = address phase, 1 = data phase
//   rtc_bus_out, rtc_bus_oe : pad data and output enable
module rtc_timer_writer
    import rtc_pkg::*;
#(
    parameter int         T_SETUP   = 2,
    parameter int         T_STROBE  = 4,
    parameter int         T_HOLD    = 2,
    parameter logic [7:0] ADDR_BASE = DEF_ADDR_BASE,
    parameter logic [7:0] ADDR_CMD  = DEF_ADDR_CMD,
    parameter logic [7:0] CMD_START = DEF_CMD_START
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] in_hora,
    input  logic [7:0] in_min,
    input  logic [7:0] in_seg,
    output logic       busy,
    output logic       done,
    output logic       rtc_cs_n,
    output logic       rtc_wr_n,
    output logic       rtc_rd_n,
    output logic       rtc_ad,
    output logic [7:0] rtc_bus_out,
    output logic       rtc_bus_oe
);

    wr_state_e  state, state_next;
    logic [1:0] idx, idx_next;
    logic [7:0] seg_q, min_q, hora_q;
    logic       go;
    logic [1:0] go_stage;
    logic       ph_last;
    logic       a_next, d_next;
    logic [7:0] addr_next, data_next;

    rtc_bus_phase #(
        .T_SETUP  (T_SETUP),
        .T_STROBE (T_STROBE),
        .T_HOLD   (T_HOLD)
    ) u_phase (
        .clk      (clk),
        .reset    (reset),
        .go       (go),
        .stage    (go_stage),
        .strobe_n (rtc_wr_n),
        .last     (ph_last)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            idx   <= 2'd0;
        end else begin
            state <= state_next;
            idx   <= idx_next;
        end
    end

    // Every stage entry pulses go so the dwell sequencer reloads in step
    // with the state register.
    always_comb begin
        state_next = state;
        idx_next   = idx;
        go         = 1'b0;
        go_stage   = PH_SETUP;
        case (state)
            IDLE: if (start) begin
                state_next = A_SETUP;
                idx_next   = 2'd0;
                go         = 1'b1;
            end
            A_SETUP:  if (ph_last) begin state_next = A_STROBE; go = 1'b1; go_stage = PH_STROBE; end
            A_STROBE: if (ph_last) begin state_next = A_HOLD;   go = 1'b1; go_stage = PH_HOLD;   end
            A_HOLD:   if (ph_last) begin state_next = D_SETUP;  go = 1'b1; go_stage = PH_SETUP;  end
            D_SETUP:  if (ph_last) begin state_next = D_STROBE; go = 1'b1; go_stage = PH_STROBE; end
            D_STROBE: if (ph_last) begin state_next = D_HOLD;   go = 1'b1; go_stage = PH_HOLD;   end
            D_HOLD:   if (ph_last) state_next = GAP;
            GAP: begin
                if (idx == LAST_INDEX) begin
                    state_next = DONE;
                end else begin
                    state_next = A_SETUP;
                    idx_next   = idx + 2'd1;
                    go         = 1'b1;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        a_next = (state_next == A_SETUP) || (state_next == A_STROBE) || (state_next == A_HOLD);
        d_next = (state_next == D_SETUP) || (state_next == D_STROBE) || (state_next == D_HOLD);
        case (idx_next)
            2'd0:    begin addr_next = ADDR_BASE;        data_next = seg_q;     end
            2'd1:    begin addr_next = ADDR_BASE + 8'd1; data_next = min_q;     end
            2'd2:    begin addr_next = ADDR_BASE + 8'd2; data_next = hora_q;    end
            default: begin addr_next = ADDR_CMD;         data_next = CMD_START; end
        endcase
    end

    // Pins are registered from the next-state decode so they change exactly
    // on the cycle the sequencer enters a state.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy        <= 1'b0;
            done        <= 1'b0;
            rtc_cs_n    <= BUS_IDLE_CS_N;
            rtc_bus_oe  <= BUS_IDLE_OE;
            rtc_ad      <= 1'b1;
            rtc_bus_out <= 8'h00;
            seg_q       <= 8'h00;
            min_q       <= 8'h00;
            hora_q      <= 8'h00;
        end else begin
            if (state == IDLE && start) begin
                seg_q  <= in_seg;
                min_q  <= in_min;
                hora_q <= in_hora;
            end
            busy        <= (state_next != IDLE) && (state_next != DONE);
            done        <= (state_next == DONE);
            rtc_cs_n    <= (a_next || d_next) ? 1'b0 : BUS_IDLE_CS_N;
            rtc_bus_oe  <= (a_next || d_next) ? 1'b1 : BUS_IDLE_OE;
            rtc_ad      <= !a_next;
            rtc_bus_out <= a_next ? addr_next : (d_next ? data_next : 8'h00);
        end
    end

    assign rtc_rd_n = 1'b1;

endmodule

// File: tb/tb_rtc_timer_writer.sv
// tb/tb_rtc_timer_writer.sv - self-checking bench for rtc_timer_writer
module tb_rtc_timer_writer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [7:0] in_hora = 8'h00, in_min = 8'h00, in_seg = 8'h00;

    logic       busy0, done0, cs0, wr0, rd0, ad0, oe0;
    logic [7:0] bus0;
    logic       busy1, done1, cs1, wr1, rd1, ad1, oe1;
    logic [7:0] bus1;

    int errors = 0;
    int checks = 0;
    bit chk_en = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    rtc_timer_writer u_dut0 (
        .clk(clk), .reset(reset), .start(start),
        .in_hora(in_hora), .in_min(in_min), .in_seg(in_seg),
        .busy(busy0), .done(done0), .rtc_cs_n(cs0), .rtc_wr_n(wr0), .rtc_rd_n(rd0),
        .rtc_ad(ad0), .rtc_bus_out(bus0), .rtc_bus_oe(oe0)
    );

    rtc_timer_writer #(
        .T_SETUP(1), .T_STROBE(1), .T_HOLD(1), .ADDR_BASE(8'hFF)
    ) u_dut1 (
        .clk(clk), .reset(reset), .start(start),
        .in_hora(in_hora), .in_min(in_min), .in_seg(in_seg),
        .busy(busy1), .done(done1), .rtc_cs_n(cs1), .rtc_wr_n(wr1), .rtc_rd_n(rd1),
        .rtc_ad(ad1), .rtc_bus_out(bus1), .rtc_bus_oe(oe1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Pin vector order: {busy, done, cs_n, wr_n, rd_n, ad, oe, bus[7:0]}
    localparam logic [14:0] IDLE_V = {1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00};

    // Expected pins at cycle offset off after the accepting edge (0 = first busy cycle).
    function automatic logic [14:0] exp_at(input int off, input int ts, input int tw, input int th,
                                           input logic [7:0] base, input logic [7:0] seg,
                                           input logic [7:0] mn, input logic [7:0] hr);
        int p, xl, x, r, s;
        logic [7:0] addr, data;
        logic wr;
        p  = ts + tw + th;
        xl = 2 * p + 1;
        if (off == 4 * xl) return {1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00};
        if (off < 0 || off > 4 * xl) return IDLE_V;
        x = off / xl;
        r = off % xl;
        if (r == 2 * p) return {1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00};
        case (x)
            0:       begin addr = base;        data = seg;   end
            1:       begin addr = base + 8'd1; data = mn;    end
            2:       begin addr = base + 8'd2; data = hr;    end
            default: begin addr = 8'hF2;       data = 8'h08; end
        endcase
        s  = r % p;
        wr = !(s >= ts && s < ts + tw);
        return {1'b1, 1'b0, 1'b0, wr, 1'b1, (r >= p), 1'b1, (r >= p) ? data : addr};
    endfunction

    // Reference model: a transaction is just an offset walking through the
    // fixed timeline; the extra idle slot after done is where start is ignored.
    logic [14:0] exp0 = IDLE_V, exp1 = IDLE_V;
    bit          act0 = 0, act1 = 0;
    int          off0 = 0, off1 = 0;
    logic [7:0]  s0, n0, h0, s1, n1, h1;

    always @(posedge clk) begin
        if (reset) act0 = 0;
        else if (act0) begin off0++; if (off0 > 4 * 17) act0 = 0; end
        else if (start) begin act0 = 1; off0 = 0; s0 = in_seg; n0 = in_min; h0 = in_hora; end
        exp0 = act0 ? exp_at(off0, 2, 4, 2, 8'h41, s0, n0, h0) : IDLE_V;
    end

    always @(posedge clk) begin
        if (reset) act1 = 0;
        else if (act1) begin off1++; if (off1 > 4 * 7) act1 = 0; end
        else if (start) begin act1 = 1; off1 = 0; s1 = in_seg; n1 = in_min; h1 = in_hora; end
        exp1 = act1 ? exp_at(off1, 1, 1, 1, 8'hFF, s1, n1, h1) : IDLE_V;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("dut0_pins", {17'd0, busy0, done0, cs0, wr0, rd0, ad0, oe0, bus0}, {17'd0, exp0});
            check("dut1_pins", {17'd0, busy1, done1, cs1, wr1, rd1, ad1, oe1, bus1}, {17'd0, exp1});
        end
    end

    // Bus activity logs used for the hand-computed expectations.
    logic [8:0] log0[$], log1[$];
    int lens0[$], lens1[$], rise0[$], rise1[$];
    int run0 = 0, run1 = 0, busy_n0 = 0, busy_n1 = 0, done_n0 = 0, done_n1 = 0;
    logic pw0 = 1'b1, pw1 = 1'b1, pb0 = 1'b0, pb1 = 1'b0;

    always @(negedge clk) begin
        if (wr0 === 1'b0 && pw0 === 1'b1) log0.push_back({ad0, bus0});
        if (wr0 === 1'b0) run0++;
        else if (pw0 === 1'b0) begin lens0.push_back(run0); run0 = 0; end
        if (busy0 === 1'b1) busy_n0++;
        if (done0 === 1'b1) done_n0++;
        if (busy0 === 1'b1 && pb0 !== 1'b1) rise0.push_back(cyc);
        pw0 = wr0; pb0 = busy0;
        if (wr1 === 1'b0 && pw1 === 1'b1) log1.push_back({ad1, bus1});
        if (wr1 === 1'b0) run1++;
        else if (pw1 === 1'b0) begin lens1.push_back(run1); run1 = 0; end
        if (busy1 === 1'b1) busy_n1++;
        if (done1 === 1'b1) done_n1++;
        if (busy1 === 1'b1 && pb1 !== 1'b1) rise1.push_back(cyc);
        pw1 = wr1; pb1 = busy1;
    end

    int bl0, bl1, bn0, bn1, bb0, bb1, bd0, bd1, br0, br1;

    task automatic snap();
        bl0 = log0.size();  bl1 = log1.size();
        bn0 = lens0.size(); bn1 = lens1.size();
        bb0 = busy_n0;      bb1 = busy_n1;
        bd0 = done_n0;      bd1 = done_n1;
        br0 = rise0.size(); br1 = rise1.size();
    endtask

    function automatic logic [31:0] lg0(input int i);
        return (bl0 + i < log0.size()) ? 32'(log0[bl0 + i]) : 32'hFFFF_FFFF;
    endfunction
    function automatic logic [31:0] lg1(input int i);
        return (bl1 + i < log1.size()) ? 32'(log1[bl1 + i]) : 32'hFFFF_FFFF;
    endfunction

    task automatic wait_done0(input string name);
        int n;
        n = 0;
        while (done0 !== 1'b1 && n < 300) begin @(negedge clk); n++; end
        check(name, 32'(n < 300), 32'd1);
    endtask

    logic [8:0] exp_log0[8];
    logic [8:0] exp_log1[8];
    logic [7:0] keep_seg;

    initial begin
        exp_log0 = '{9'h041, 9'h145, 9'h042, 9'h130, 9'h043, 9'h101, 9'h0F2, 9'h108};
        exp_log1 = '{9'h0FF, 9'h145, 9'h000, 9'h130, 9'h001, 9'h101, 9'h0F2, 9'h108};

        @(negedge clk);
        chk_en = 1;
        @(negedge clk);
        reset = 0;
        repeat (3) @(negedge clk);

        // Reset while idle
        reset = 1;
        repeat (3) begin
            @(negedge clk);
            check("rst_busy", 32'(busy0), 32'd0);
            check("rst_rd_n", 32'(rd0), 32'd1);
            check("rst_cs_n", 32'(cs0), 32'd1);
        end
        reset = 0;
        repeat (2) @(negedge clk);

        // Nominal write, plus input change and start pulse at about k+10
        snap();
        in_hora = 8'h01; in_min = 8'h30; in_seg = 8'h45; start = 1;
        @(negedge clk);
        start = 0;
        repeat (8) @(negedge clk);
        in_hora = 8'h23; in_min = 8'h59; in_seg = 8'h58; start = 1;
        @(negedge clk);
        start = 0;
        wait_done0("t2_done_reached");
        repeat (3) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            check("t2_log0", lg0(i), 32'(exp_log0[i]));
            check("t2_strobe0_len", (bn0 + i < lens0.size()) ? 32'(lens0[bn0 + i]) : 32'hFFFF, 32'd4);
            check("t6_log1", lg1(i), 32'(exp_log1[i]));
            check("t6_strobe1_len", (bn1 + i < lens1.size()) ? 32'(lens1[bn1 + i]) : 32'hFFFF, 32'd1);
        end
        check("t2_log0_count", 32'(log0.size() - bl0), 32'd8);
        check("t2_busy0_cycles", 32'(busy_n0 - bb0), 32'd68);
        check("t2_done0_cycles", 32'(done_n0 - bd0), 32'd1);
        check("t6_busy1_cycles", 32'(busy_n1 - bb1), 32'd28);
        check("t6_done1_cycles", 32'(done_n1 - bd1), 32'd1);

        // Start held high: restarts 70 (resp. 30) cycles apart, no overlap
        snap();
        start = 1;
        repeat (160) @(negedge clk);
        start = 0;
        repeat (90) @(negedge clk);
        check("t4_rise0_gap", (rise0.size() >= br0 + 2) ? 32'(rise0[br0 + 1] - rise0[br0]) : 32'hFFFF, 32'd70);
        check("t4_rise1_gap", (rise1.size() >= br1 + 2) ? 32'(rise1[br1 + 1] - rise1[br1]) : 32'hFFFF, 32'd30);

        // Reset during the index-2 address strobe
        snap();
        in_seg = 8'h12; in_min = 8'h34; in_hora = 8'h05; start = 1;
        @(negedge clk);
        start = 0;
        for (int n = 0; n < 100 && !(log0.size() >= bl0 + 5 && wr0 === 1'b0); n++) @(negedge clk);
        check("t5_reached_idx2", lg0(4), 32'h043);
        reset = 1;
        @(negedge clk);
        check("t5_wr_n", 32'(wr0), 32'd1);
        check("t5_cs_n", 32'(cs0), 32'd1);
        check("t5_oe", 32'(oe0), 32'd0);
        check("t5_busy", 32'(busy0), 32'd0);
        reset = 0;
        repeat (3) @(negedge clk);
        check("t5_no_done", 32'(done_n0 - bd0), 32'd0);
        snap();
        keep_seg = in_seg;
        start = 1;
        @(negedge clk);
        start = 0;
        wait_done0("t5_restart_done");
        repeat (3) @(negedge clk);
        check("t5_restart_first_addr", lg0(0), 32'h041);
        check("t5_restart_first_data", lg0(1), 32'({1'b1, keep_seg}));
        check("t5_restart_cmd", lg0(7), 32'h108);
        check("t5_restart_count", 32'(log0.size() - bl0), 32'd8);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            start   = ($urandom_range(0, 9) == 0);
            reset   = ($urandom_range(0, 299) == 0);
            in_hora = 8'($urandom);
            in_min  = 8'($urandom);
            in_seg  = 8'($urandom);
        end
        reset = 0;
        start = 0;
        repeat (90) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
